pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Control block that drives the program counter's LoadEnable/OffsetEnable/LoadValue/Offset inputs from decoded control-flow commands.
- Handles jumps, conditional relative branches, call/return through a small return-address stack, halt, and stalls on instruction-fetch backpressure.
- The program counter increments whenever neither enable is asserted, so this block holds it by reloading its current value.
- Sits between the decode stage and the program counter; the program counter's output is fed back in.

Parameters:
STACK_DEPTH, 4, number of return-address stack entries (power of two, 2..16)
ADDR_W, 16, program address width (must match program counter)
OFS_W, 9, signed relative offset width (must match program counter)

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
CounterValue  in  ADDR_W  current program counter value (feedback)
FetchReady  in  1  instruction memory accepts fetch at CounterValue this cycle
CmdValid  in  1  decoded command present
CmdReady  out  1  command consumed this cycle
CmdType  in  3  pc_seq_pkg::cmd_e
CmdTarget  in  ADDR_W  absolute target (JUMP, CALL)
CmdOffset  in  OFS_W  signed two's-complement offset (BRANCH)
CondTrue  in  1  branch condition, sampled with BRANCH
Resume  in  1  leave HALT/FAULT
LoadEnable  out  1  to program counter
OffsetEnable  out  1  to program counter
LoadValue  out  ADDR_W  to program counter
Offset  out  OFS_W  to program counter
Halted  out  1  state == HALT
Fault  out  1  state == FAULT
StackCount  out  $clog2(STACK_DEPTH)+1  valid stack entries

Behaviour:
- Reset is asynchronous and active-high. Clock is Clock. Reset is honoured mid-operation.
- Reset values: state RUN, StackCount 0, stack contents don't-care.
  - While Reset is high, all outputs are 0 except CmdReady, which is also 0.
- States: RUN, HALT, FAULT (state_e). Outputs are combinational from state and inputs; the program counter registers them, so a command's effect is visible on CounterValue one edge later.
- HOLD action: LoadEnable=1, LoadValue=CounterValue, OffsetEnable=0.
- Priority per cycle:
  1. HALT/FAULT → HOLD, CmdReady=0.
  2. RUN with FetchReady=0 → HOLD, CmdReady=0 (stall; the command stays pending).
  3. RUN with FetchReady=1 → CmdReady=1; execute the command if CmdValid, else increment (both enables 0).
- Commands (executed only when CmdValid & CmdReady):
  - NOP: enables 0 (increment).
  - JUMP: LoadEnable=1, LoadValue=CmdTarget.
  - BRANCH: if CondTrue then OffsetEnable=1, Offset=CmdOffset passed unchanged; else enables 0 (fall through).
  - CALL: push CounterValue+1 (mod 2^ADDR_W; 16'hFFFF pushes 16'h0000); LoadEnable=1, LoadValue=CmdTarget; StackCount++.
  - RET: pop; LoadEnable=1, LoadValue=top entry; StackCount--.
  - HALT: HOLD this cycle; next state HALT.
  - Undefined encodings: treated as FAULT.
- Boundary conditions:
  - CALL with StackCount==STACK_DEPTH → no push, HOLD, next state FAULT.
  - RET with StackCount==0 → HOLD, next state FAULT.
- Resume in HALT or FAULT → next state RUN. StackCount is preserved on leaving HALT and cleared on leaving FAULT. Resume in RUN is ignored.
- LoadEnable and OffsetEnable are never both 1.
- Outputs LoadValue and Offset are 0 whenever their enable is 0.

Decomposition:
- pc_seq_pkg:
  - cmd_e: NOP=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HALT=5.
  - state_e.
  - ADDR_W/OFS_W defaults.
- Sub-module return_stack: synchronous LIFO with push/pop/top/count/full/empty ports, reset via Reset. It has no awareness of commands.
- pc_sequencer holds the FSM and the output mux.

Test Plan:
- Reset asserted mid-CALL (StackCount=2) → all outputs 0 immediately; after release StackCount=0, state RUN, enables 0.
- CounterValue=0x0010, FetchReady=0 for 3 cycles with JUMP 0x0200 pending → LoadEnable=1, LoadValue=0x0010, CmdReady=0 for 3 cycles; on FetchReady=1 → LoadValue=0x0200, CmdReady=1.
- BRANCH with CmdOffset=-3 (9'h1FD):
  - CondTrue=1 → OffsetEnable=1, Offset=9'h1FD.
  - CondTrue=0 → both enables 0.
- CALL 0x0100 at CounterValue=0x0040, then RET at 0x0105 → first LoadValue=0x0100, StackCount=1; then LoadValue=0x0041, StackCount=0.
- STACK_DEPTH=4: five CALLs → fifth holds the PC, Fault=1, StackCount=4. Resume → RUN, StackCount=0. RET then → Fault=1.
- HALT then idle 5 cycles → HOLD each cycle, Halted=1. Resume → next cycle Halted=0, increment resumes.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Command encodings come from the decode stage; undefined codes fault.
package pc_seq_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int OFS_W_DEF       = 9;
  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_JUMP   = 3'd1,
    CMD_BRANCH = 3'd2,
    CMD_CALL   = 3'd3,
    CMD_RET    = 3'd4,
    CMD_HALT   = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // What the program counter is told to do this cycle.
  typedef enum logic [2:0] {
    ACT_INC    = 3'd0,
    ACT_HOLD   = 3'd1,
    ACT_TARGET = 3'd2,
    ACT_RETURN = 3'd3,
    ACT_OFFSET = 3'd4
  } action_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Synchronous LIFO of return addresses. Push wins over pop; overflow and
// underflow requests are ignored here and policed by the caller.
module return_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int W     = ADDR_W_DEF
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_top,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W - 1){1'b0}}, 1'b1};

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_wr_idx  = r_count[PTR_W-1:0];
  assign w_top_idx = w_wr_idx - PTR_ONE;
  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_top     = r_mem[w_top_idx];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty && !i_push;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + CNT_ONE;
    end else if (w_do_pop) begin
      r_count <= r_count - CNT_ONE;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge Clock) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Drives the program counter's load/offset controls from decoded control-flow
// commands. Outputs are combinational; the counter registers them.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int OFS_W       = OFS_W_DEF
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [ADDR_W-1:0]            CounterValue,
  input  logic                         FetchReady,
  input  logic                         CmdValid,
  output logic                         CmdReady,
  input  logic [2:0]                   CmdType,
  input  logic [ADDR_W-1:0]            CmdTarget,
  input  logic [OFS_W-1:0]             CmdOffset,
  input  logic                         CondTrue,
  input  logic                         Resume,
  output logic                         LoadEnable,
  output logic                         OffsetEnable,
  output logic [ADDR_W-1:0]            LoadValue,
  output logic [OFS_W-1:0]             Offset,
  output logic                         Halted,
  output logic                         Fault,
  output logic [$clog2(STACK_DEPTH):0] StackCount
);

  // Handshake: a command is consumed on any cycle where CmdValid && CmdReady;
  // CmdReady depends only on state and FetchReady, never on CmdValid.

  state_e              r_state;
  state_e              w_next_state;
  action_e             w_action;
  logic                w_rdy;
  logic                w_exec;
  logic                w_push;
  logic                w_pop;
  logic                w_clear;
  logic [ADDR_W-1:0]   w_top;
  logic [ADDR_W-1:0]   w_ret_addr;
  logic                w_full;
  logic                w_empty;

  assign w_exec     = (r_state == ST_RUN) && FetchReady && CmdValid;
  assign w_ret_addr = CounterValue + ADDR_W'(1);

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_ret_addr),
    .o_top   (w_top),
    .o_count (StackCount),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_exec) begin
          case (CmdType)
            CMD_NOP, CMD_JUMP, CMD_BRANCH: w_next_state = ST_RUN;
            CMD_CALL: if (w_full)  w_next_state = ST_FAULT;
            CMD_RET:  if (w_empty) w_next_state = ST_FAULT;
            CMD_HALT: w_next_state = ST_HALT;
            default:  w_next_state = ST_FAULT;
          endcase
        end
      end
      ST_HALT, ST_FAULT: begin
        if (Resume) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_FAULT;
    endcase
  end

  always_comb begin
    w_action = ACT_INC;
    w_rdy    = 1'b0;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_clear  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!FetchReady) begin
          w_action = ACT_HOLD;
        end else begin
          w_rdy = 1'b1;
          if (CmdValid) begin
            case (CmdType)
              CMD_NOP:    w_action = ACT_INC;
              CMD_JUMP:   w_action = ACT_TARGET;
              CMD_BRANCH: w_action = CondTrue ? ACT_OFFSET : ACT_INC;
              CMD_CALL: begin
                if (w_full) begin
                  w_action = ACT_HOLD;
                end else begin
                  w_action = ACT_TARGET;
                  w_push   = 1'b1;
                end
              end
              CMD_RET: begin
                if (w_empty) begin
                  w_action = ACT_HOLD;
                end else begin
                  w_action = ACT_RETURN;
                  w_pop    = 1'b1;
                end
              end
              default: w_action = ACT_HOLD;
            endcase
          end
        end
      end
      default: begin
        w_action = ACT_HOLD;
        // Leaving FAULT discards the stack; leaving HALT keeps it.
        w_clear  = (r_state == ST_FAULT) && Resume;
      end
    endcase
  end

  always_comb begin
    LoadEnable   = 1'b0;
    OffsetEnable = 1'b0;
    LoadValue    = '0;
    Offset       = '0;
    if (!Reset) begin
      case (w_action)
        ACT_HOLD: begin
          LoadEnable = 1'b1;
          LoadValue  = CounterValue;
        end
        ACT_TARGET: begin
          LoadEnable = 1'b1;
          LoadValue  = CmdTarget;
        end
        ACT_RETURN: begin
          LoadEnable = 1'b1;
          LoadValue  = w_top;
        end
        ACT_OFFSET: begin
          OffsetEnable = 1'b1;
          Offset       = CmdOffset;
        end
        default: begin
          LoadEnable   = 1'b0;
          OffsetEnable = 1'b0;
        end
      endcase
    end
  end

  assign CmdReady = w_rdy && !Reset;
  assign Halted   = (r_state == ST_HALT);
  assign Fault    = (r_state == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scenario tasks drive one step per
// cycle, push the expected output vector, and compare at the falling edge.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int W = 33;

  logic        Clock;
  logic        Reset;
  logic [15:0] CounterValue;
  logic        FetchReady;
  logic        CmdValid;
  logic        CmdReady;
  logic [2:0]  CmdType;
  logic [15:0] CmdTarget;
  logic [8:0]  CmdOffset;
  logic        CondTrue;
  logic        Resume;
  logic        LoadEnable;
  logic        OffsetEnable;
  logic [15:0] LoadValue;
  logic [8:0]  Offset;
  logic        Halted;
  logic        Fault;
  logic [2:0]  StackCount;

  typedef struct {
    logic         rst;
    logic         fr;
    logic         v;
    logic [2:0]   ct;
    logic [15:0]  tgt;
    logic [8:0]   ofs;
    logic         cond;
    logic         res;
    logic [15:0]  cv;
    logic [W-1:0] exp;
  } step_t;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [W-1:0] e;
  int           checks = 0;
  int           errors = 0;

  pc_sequencer #(
    .STACK_DEPTH (4),
    .ADDR_W      (16),
    .OFS_W       (9)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .CounterValue (CounterValue),
    .FetchReady   (FetchReady),
    .CmdValid     (CmdValid),
    .CmdReady     (CmdReady),
    .CmdType      (CmdType),
    .CmdTarget    (CmdTarget),
    .CmdOffset    (CmdOffset),
    .CondTrue     (CondTrue),
    .Resume       (Resume),
    .LoadEnable   (LoadEnable),
    .OffsetEnable (OffsetEnable),
    .LoadValue    (LoadValue),
    .Offset       (Offset),
    .Halted       (Halted),
    .Fault        (Fault),
    .StackCount   (StackCount)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Vector layout: {CmdReady, LoadEnable, OffsetEnable, LoadValue, Offset, Halted, Fault, StackCount}
  function automatic logic [W-1:0] ev(input int rdy, le, oe, lv, ofs, h, f, sc);
    return {1'(rdy), 1'(le), 1'(oe), 16'(lv), 9'(ofs), 1'(h), 1'(f), 3'(sc)};
  endfunction

  function automatic step_t mk(input int rst, fr, v, ct, tgt, ofs, cond, res, cv,
                               input logic [W-1:0] exp);
    step_t s;
    s.rst  = 1'(rst);
    s.fr   = 1'(fr);
    s.v    = 1'(v);
    s.ct   = 3'(ct);
    s.tgt  = 16'(tgt);
    s.ofs  = 9'(ofs);
    s.cond = 1'(cond);
    s.res  = 1'(res);
    s.cv   = 16'(cv);
    s.exp  = exp;
    return s;
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {CmdReady, LoadEnable, OffsetEnable, LoadValue, Offset, Halted, Fault, StackCount};
  endfunction

  // Driver
  task automatic apply(input step_t s);
    Reset        = s.rst;
    FetchReady   = s.fr;
    CmdValid     = s.v;
    CmdType      = s.ct;
    CmdTarget    = s.tgt;
    CmdOffset    = s.ofs;
    CondTrue     = s.cond;
    Resume       = s.res;
    CounterValue = s.cv;
  endtask

  task automatic test_reset();
    step_t s[$];
    s.push_back(mk(1, 1, 1, CMD_CALL, 'h100, 0, 0, 0, 'h40, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h40, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_stall();
    step_t s[$];
    for (int k = 0; k < 3; k++)
      s.push_back(mk(0, 0, 1, CMD_JUMP, 'h200, 0, 0, 0, 'h10, ev(0, 1, 0, 'h10, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_JUMP, 'h200, 0, 0, 0, 'h10, ev(1, 1, 0, 'h200, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_branch();
    step_t s[$];
    s.push_back(mk(0, 1, 1, CMD_BRANCH, 0, 'h1FD, 1, 0, 'h200, ev(1, 0, 1, 0, 'h1FD, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_BRANCH, 0, 'h1FD, 0, 0, 'h1FD, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, CMD_BRANCH, 0, 'h0FF, 1, 0, 'h300, ev(0, 1, 0, 'h300, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_NOP, 'h1234, 'h55, 1, 0, 'h301, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL branch[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_call_ret();
    step_t s[$];
    s.push_back(mk(0, 1, 1, CMD_CALL, 'h100, 0, 0, 0, 'h40, ev(1, 1, 0, 'h100, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_RET, 0, 0, 0, 0, 'h105, ev(1, 1, 0, 'h41, 0, 0, 0, 1)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h41, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    // Return address wraps at the top of the address space; nested order is LIFO.
    s.push_back(mk(0, 1, 1, CMD_CALL, 'h20, 0, 0, 0, 'hFFFF, ev(1, 1, 0, 'h20, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_CALL, 'h30, 0, 0, 0, 'h25, ev(1, 1, 0, 'h30, 0, 0, 0, 1)));
    s.push_back(mk(0, 1, 1, CMD_RET, 0, 0, 0, 0, 'h31, ev(1, 1, 0, 'h26, 0, 0, 0, 2)));
    s.push_back(mk(0, 1, 1, CMD_RET, 0, 0, 0, 0, 'h27, ev(1, 1, 0, 'h0, 0, 0, 0, 1)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL call_ret[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_overflow();
    step_t s[$];
    for (int k = 0; k < 4; k++)
      s.push_back(mk(0, 1, 1, CMD_CALL, 'h300 + k, 0, 0, 0, 'h50 + k, ev(1, 1, 0, 'h300 + k, 0, 0, 0, k)));
    s.push_back(mk(0, 1, 1, CMD_CALL, 'h304, 0, 0, 0, 'h303, ev(1, 1, 0, 'h303, 0, 0, 0, 4)));
    s.push_back(mk(0, 1, 1, CMD_JUMP, 'h777, 0, 0, 0, 'h303, ev(0, 1, 0, 'h303, 0, 0, 1, 4)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 1, 'h303, ev(0, 1, 0, 'h303, 0, 0, 1, 4)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h303, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_RET, 0, 0, 0, 0, 'h304, ev(1, 1, 0, 'h304, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h304, ev(0, 1, 0, 'h304, 0, 0, 1, 0)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 1, 'h304, ev(0, 1, 0, 'h304, 0, 0, 1, 0)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h304, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL overflow[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_halt();
    step_t s[$];
    s.push_back(mk(0, 1, 1, CMD_CALL, 'h400, 0, 0, 0, 'h60, ev(1, 1, 0, 'h400, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_HALT, 0, 0, 0, 0, 'h400, ev(1, 1, 0, 'h400, 0, 0, 0, 1)));
    for (int k = 0; k < 5; k++)
      s.push_back(mk(0, 1, 1, CMD_JUMP, 'h999, 0, 0, 0, 'h400, ev(0, 1, 0, 'h400, 0, 1, 0, 1)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 1, 'h400, ev(0, 1, 0, 'h400, 0, 1, 0, 1)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 1, 'h400, ev(1, 0, 0, 0, 0, 0, 0, 1)));
    s.push_back(mk(0, 1, 1, CMD_RET, 0, 0, 0, 1, 'h401, ev(1, 1, 0, 'h61, 0, 0, 0, 1)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL halt[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_undefined();
    step_t s[$];
    for (int c = 6; c < 8; c++) begin
      s.push_back(mk(0, 1, 1, c, 'h123, 0, 0, 0, 'h70, ev(1, 1, 0, 'h70, 0, 0, 0, 0)));
      s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h70, ev(0, 1, 0, 'h70, 0, 0, 1, 0)));
      s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 1, 'h70, ev(0, 1, 0, 'h70, 0, 0, 1, 0)));
      s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h70, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    end
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL undefined[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t st;
    int fr, v, ct, tgt, ofs, cond, cv;
    logic [W-1:0] x;
    for (int i = 0; i < 40; i++) begin
      fr   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      v    = $urandom_range(0, 1);
      ct   = $urandom_range(0, 2);
      tgt  = $urandom_range(0, 65535);
      ofs  = $urandom_range(0, 511);
      cond = $urandom_range(0, 1);
      cv   = $urandom_range(0, 65535);
      if (fr == 0)                              x = ev(0, 1, 0, cv, 0, 0, 0, 0);
      else if (v == 0 || ct == CMD_NOP)         x = ev(1, 0, 0, 0, 0, 0, 0, 0);
      else if (ct == CMD_JUMP)                  x = ev(1, 1, 0, tgt, 0, 0, 0, 0);
      else if (cond == 1)                       x = ev(1, 0, 1, 0, ofs, 0, 0, 0);
      else                                      x = ev(1, 0, 0, 0, 0, 0, 0, 0);
      st = mk(0, fr, v, ct, tgt, ofs, cond, 0, cv, x);
      apply(st);
      exp_q.push_back(x);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset_mid_call();
    step_t s[$];
    s.push_back(mk(0, 1, 1, CMD_CALL, 'h500, 0, 0, 0, 'h80, ev(1, 1, 0, 'h500, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_CALL, 'h510, 0, 0, 0, 'h500, ev(1, 1, 0, 'h510, 0, 0, 0, 1)));
    s.push_back(mk(1, 1, 1, CMD_CALL, 'h520, 0, 0, 0, 'h510, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h520, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, CMD_RET, 0, 0, 0, 0, 'h521, ev(1, 1, 0, 'h521, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 1, 'h521, ev(0, 1, 0, 'h521, 0, 0, 1, 0)));
    s.push_back(mk(0, 1, 0, CMD_NOP, 0, 0, 0, 0, 'h521, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge Clock);
      obs = dut_vec();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_call[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    Reset        = 1'b1;
    CounterValue = '0;
    FetchReady   = 1'b0;
    CmdValid     = 1'b0;
    CmdType      = '0;
    CmdTarget    = '0;
    CmdOffset    = '0;
    CondTrue     = 1'b0;
    Resume       = 1'b0;
    @(posedge Clock); #1;
    test_reset();
    test_stall();
    test_branch();
    test_call_ret();
    test_overflow();
    test_halt();
    test_undefined();
    test_back_to_back();
    test_reset_mid_call();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
